inst_queue: RTL and testbench

Dual-slot instruction queue between fetch and `Decoder`. Buffers up to `DEPTH` fetched instructions (pc + 32-bit encoding) in program order and presents the two oldest entries to the decoder on the `inst0_f1_*` / `inst1_f1_*` interface. Honours the decoder's scoreboard stalls and the writeback flush.

---
 rtl/iq_pkg.sv | 12 +
 rtl/iq_storage.sv | 32 +++
 rtl/inst_queue.sv | 105 ++++++++++
 tb/tb_inst_queue.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/iq_pkg.sv
// Shared types and constants for the dual-slot instruction queue.
package iq_pkg;

  localparam int IQ_DEPTH_DEFAULT = 8;
  localparam int ISSUE_WIDTH      = 2;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } iq_entry_t;

endpackage

// File: rtl/iq_storage.sv
// Entry array for the instruction queue: two write ports, two combinational read ports.
module iq_storage
  import iq_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEFAULT,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we0,
  input  logic [PTR_W-1:0] waddr0,
  input  iq_entry_t        wdata0,
  input  logic             we1,
  input  logic [PTR_W-1:0] waddr1,
  input  iq_entry_t        wdata1,
  input  logic [PTR_W-1:0] raddr0,
  output iq_entry_t        rdata0,
  input  logic [PTR_W-1:0] raddr1,
  output iq_entry_t        rdata1
);

  iq_entry_t mem [DEPTH];

  // NOTE: the array has no reset; occupancy lives in the pointers, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/inst_queue.sv
// Dual-slot FIFO between fetch and decode; presents the two oldest entries first-word-fall-through.
module inst_queue
  import iq_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEFAULT,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           fetch_inst0_valid_i,
  input  logic [63:0]    fetch_inst0_pc_i,
  input  logic [31:0]    fetch_inst0_inst_i,
  input  logic           fetch_inst1_valid_i,
  input  logic [63:0]    fetch_inst1_pc_i,
  input  logic [31:0]    fetch_inst1_inst_i,
  output logic           fetch_ready_o,
  input  logic           stall_decoder_inst0_i,
  input  logic           stall_decoder_inst1_i,
  input  logic           flush_iq_i,
  output logic           inst0_f1_valid_o,
  output logic [63:0]    inst0_f1_pc_o,
  output logic [31:0]    inst0_f1_inst_o,
  output logic           inst1_f1_valid_o,
  output logic [63:0]    inst1_f1_pc_o,
  output logic [31:0]    inst1_f1_inst_o,
  output logic [PTR_W:0] iq_count_o
);

  localparam int CNT_W = PTR_W + 1;
  localparam int NUM_W = $clog2(ISSUE_WIDTH + 1);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - ISSUE_WIDTH);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq, deq, we0, we1;
  logic [NUM_W-1:0] n_enq, n_deq;
  iq_entry_t        wdata0, wdata1, rdata0, rdata1;

  // Ready depends only on registered occupancy, never on stall or flush.
  assign fetch_ready_o    = (count_q <= READY_MAX);
  assign inst0_f1_valid_o = (count_q != '0);
  assign inst1_f1_valid_o = (count_q >= CNT_W'(2));

  assign enq   = fetch_ready_o && !flush_iq_i;
  assign deq   = !stall_decoder_inst0_i && !stall_decoder_inst1_i;
  assign n_enq = NUM_W'(fetch_inst0_valid_i) + NUM_W'(fetch_inst1_valid_i);
  assign n_deq = NUM_W'(inst0_f1_valid_o) + NUM_W'(inst1_f1_valid_o);

  // A lone slot-1 instruction is packed into the tail slot through port 0.
  assign we0    = enq && (fetch_inst0_valid_i || fetch_inst1_valid_i);
  assign we1    = enq && fetch_inst0_valid_i && fetch_inst1_valid_i;
  assign wdata0 = fetch_inst0_valid_i ? {fetch_inst0_pc_i, fetch_inst0_inst_i}
                                      : {fetch_inst1_pc_i, fetch_inst1_inst_i};
  assign wdata1 = {fetch_inst1_pc_i, fetch_inst1_inst_i};

  iq_storage #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_storage (
    .clk    (clk),
    .we0    (we0),
    .waddr0 (tail_q),
    .wdata0 (wdata0),
    .we1    (we1),
    .waddr1 (tail_q + PTR_W'(1)),
    .wdata1 (wdata1),
    .raddr0 (head_q),
    .rdata0 (rdata0),
    .raddr1 (head_q + PTR_W'(1)),
    .rdata1 (rdata1)
  );

  // NOTE: combinational blocks use blocking assignments and default every output first, so no latch is inferred.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_iq_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + PTR_W'(n_enq);
      if (deq) head_d = head_q + PTR_W'(n_deq);
      count_d = count_q + (enq ? CNT_W'(n_enq) : '0) - (deq ? CNT_W'(n_deq) : '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign inst0_f1_pc_o   = inst0_f1_valid_o ? rdata0.pc   : '0;
  assign inst0_f1_inst_o = inst0_f1_valid_o ? rdata0.inst : '0;
  assign inst1_f1_pc_o   = inst1_f1_valid_o ? rdata1.pc   : '0;
  assign inst1_f1_inst_o = inst1_f1_valid_o ? rdata1.inst : '0;
  assign iq_count_o      = count_q;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: queue-based scoreboard plus per-scenario checks.
module tb_inst_queue;
  import iq_pkg::*;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           fetch_inst0_valid_i = 1'b0, fetch_inst1_valid_i = 1'b0;
  logic [63:0]    fetch_inst0_pc_i = '0, fetch_inst1_pc_i = '0;
  logic [31:0]    fetch_inst0_inst_i = '0, fetch_inst1_inst_i = '0;
  logic           stall_decoder_inst0_i = 1'b0, stall_decoder_inst1_i = 1'b0;
  logic           flush_iq_i = 1'b0;
  logic           fetch_ready_o;
  logic           inst0_f1_valid_o, inst1_f1_valid_o;
  logic [63:0]    inst0_f1_pc_o, inst1_f1_pc_o;
  logic [31:0]    inst0_f1_inst_o, inst1_f1_inst_o;
  logic [PTR_W:0] iq_count_o;

  int checks = 0;
  int errors = 0;
  iq_entry_t   mq[$];
  logic [63:0] obs_q[$];

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_inst0_valid_i(fetch_inst0_valid_i), .fetch_inst0_pc_i(fetch_inst0_pc_i),
    .fetch_inst0_inst_i(fetch_inst0_inst_i),
    .fetch_inst1_valid_i(fetch_inst1_valid_i), .fetch_inst1_pc_i(fetch_inst1_pc_i),
    .fetch_inst1_inst_i(fetch_inst1_inst_i),
    .fetch_ready_o(fetch_ready_o),
    .stall_decoder_inst0_i(stall_decoder_inst0_i), .stall_decoder_inst1_i(stall_decoder_inst1_i),
    .flush_iq_i(flush_iq_i),
    .inst0_f1_valid_o(inst0_f1_valid_o), .inst0_f1_pc_o(inst0_f1_pc_o), .inst0_f1_inst_o(inst0_f1_inst_o),
    .inst1_f1_valid_o(inst1_f1_valid_o), .inst1_f1_pc_o(inst1_f1_pc_o), .inst1_f1_inst_o(inst1_f1_inst_o),
    .iq_count_o(iq_count_o)
  );

  function automatic logic [31:0] enc(input logic [63:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  // Scoreboard comparison: DUT outputs against the head of the expected-entry queue.
  task automatic sb_compare();
    logic [63:0] e_pc0, e_pc1;
    logic [31:0] e_in0, e_in1;
    e_pc0 = (mq.size() >= 1) ? mq[0].pc : '0;
    e_in0 = (mq.size() >= 1) ? mq[0].inst : '0;
    e_pc1 = (mq.size() >= 2) ? mq[1].pc : '0;
    e_in1 = (mq.size() >= 2) ? mq[1].inst : '0;
    checks += 8;
    if (iq_count_o !== 4'(mq.size())) begin errors++; $display("FAIL sb_count: got %0d expected %0d", iq_count_o, mq.size()); end
    if (fetch_ready_o !== (mq.size() <= DEPTH - 2)) begin errors++; $display("FAIL sb_ready: got %0b expected %0b", fetch_ready_o, mq.size() <= DEPTH - 2); end
    if (inst0_f1_valid_o !== (mq.size() >= 1)) begin errors++; $display("FAIL sb_valid0: got %0b expected %0b", inst0_f1_valid_o, mq.size() >= 1); end
    if (inst1_f1_valid_o !== (mq.size() >= 2)) begin errors++; $display("FAIL sb_valid1: got %0b expected %0b", inst1_f1_valid_o, mq.size() >= 2); end
    if (inst0_f1_pc_o !== e_pc0) begin errors++; $display("FAIL sb_pc0: got %0h expected %0h", inst0_f1_pc_o, e_pc0); end
    if (inst0_f1_inst_o !== e_in0) begin errors++; $display("FAIL sb_inst0: got %0h expected %0h", inst0_f1_inst_o, e_in0); end
    if (inst1_f1_pc_o !== e_pc1) begin errors++; $display("FAIL sb_pc1: got %0h expected %0h", inst1_f1_pc_o, e_pc1); end
    if (inst1_f1_inst_o !== e_in1) begin errors++; $display("FAIL sb_inst1: got %0h expected %0h", inst1_f1_inst_o, e_in1); end
  endtask

  // One clock of stimulus; the expected queue is updated at the edge and compared after it.
  task automatic step(input logic v0, input logic [63:0] p0, input logic v1, input logic [63:0] p1,
                      input logic s0, input logic s1, input logic fl, output logic accepted);
    logic deq;
    fetch_inst0_valid_i = v0; fetch_inst0_pc_i = p0; fetch_inst0_inst_i = enc(p0);
    fetch_inst1_valid_i = v1; fetch_inst1_pc_i = p1; fetch_inst1_inst_i = enc(p1);
    stall_decoder_inst0_i = s0; stall_decoder_inst1_i = s1; flush_iq_i = fl;
    accepted = (mq.size() <= DEPTH - 2) && !fl;
    deq = !s0 && !s1;
    if (deq && !fl) begin
      if (inst0_f1_valid_o) obs_q.push_back(inst0_f1_pc_o);
      if (inst1_f1_valid_o) obs_q.push_back(inst1_f1_pc_o);
    end
    @(posedge clk);
    #1;
    if (fl) mq.delete();
    else begin
      if (deq) for (int i = 0; i < 2; i++) if (mq.size() > 0) void'(mq.pop_front());
      if (accepted && v0) mq.push_back('{pc: p0, inst: enc(p0)});
      if (accepted && v1) mq.push_back('{pc: p1, inst: enc(p1)});
    end
    fetch_inst0_valid_i = 1'b0; fetch_inst1_valid_i = 1'b0; flush_iq_i = 1'b0;
    sb_compare();
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, 0, 0, acc);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    checks += 4;
    if (inst0_f1_valid_o !== 1'b0 || inst1_f1_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b%0b expected 00", inst0_f1_valid_o, inst1_f1_valid_o); end
    if (inst0_f1_pc_o !== '0 || inst1_f1_pc_o !== '0 || inst0_f1_inst_o !== '0 || inst1_f1_inst_o !== '0) begin errors++; $display("FAIL reset_data: got %0h/%0h expected 0", inst0_f1_pc_o, inst1_f1_pc_o); end
    if (iq_count_o !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", iq_count_o); end
    if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", fetch_ready_o); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic acc;
    step(1, 64'h1000, 1, 64'h1004, 0, 0, 0, acc);
    checks += 3;
    if (inst0_f1_pc_o !== 64'h1000) begin errors++; $display("FAIL basic_pc0: got %0h expected 1000", inst0_f1_pc_o); end
    if (inst1_f1_pc_o !== 64'h1004) begin errors++; $display("FAIL basic_pc1: got %0h expected 1004", inst1_f1_pc_o); end
    if (iq_count_o !== 4'd2) begin errors++; $display("FAIL basic_count: got %0d expected 2", iq_count_o); end
    idle(1);
    checks++;
    if (iq_count_o !== 4'd0) begin errors++; $display("FAIL basic_drain: got %0d expected 0", iq_count_o); end
  endtask

  task automatic test_full();
    logic acc;
    for (int i = 0; i < 4; i++) step(1, 64'h2000 + 8 * i, 1, 64'h2004 + 8 * i, 0, 1, 0, acc);
    checks += 2;
    if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b expected 0", fetch_ready_o); end
    if (iq_count_o !== 4'd8) begin errors++; $display("FAIL full_count: got %0d expected 8", iq_count_o); end
    step(1, 64'h2100, 1, 64'h2104, 0, 1, 0, acc);
    checks++;
    if (iq_count_o !== 4'd8) begin errors++; $display("FAIL full_ignore: got %0d expected 8", iq_count_o); end
    obs_q.delete();
    for (int i = 0; i < 4; i++) begin
      step(0, '0, 0, '0, 0, 0, 0, acc);
      checks++;
      if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL full_reready: got %0b expected 1 (drain %0d)", fetch_ready_o, i); end
    end
    checks++;
    if (obs_q.size() != 8) begin errors++; $display("FAIL full_drain_len: got %0d expected 8", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 8; i++) begin
      checks++;
      if (obs_q[i] !== 64'h2000 + 4 * i) begin errors++; $display("FAIL full_drain_pc: got %0h expected %0h", obs_q[i], 64'h2000 + 4 * i); end
    end
    step(1, 64'h2200, 0, '0, 0, 1, 0, acc);
    for (int i = 0; i < 3; i++) step(1, 64'h2204 + 8 * i, 1, 64'h2208 + 8 * i, 0, 1, 0, acc);
    checks += 2;
    if (iq_count_o !== 4'd7) begin errors++; $display("FAIL seven_count: got %0d expected 7", iq_count_o); end
    if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL seven_ready: got %0b expected 0", fetch_ready_o); end
    idle(4);
  endtask

  task automatic test_simultaneous();
    logic acc;
    step(1, 64'h3000, 0, '0, 1, 0, 0, acc);
    step(1, 64'h3004, 1, 64'h3008, 0, 0, 0, acc);
    checks += 2;
    if (iq_count_o !== 4'd2) begin errors++; $display("FAIL simul_count: got %0d expected 2", iq_count_o); end
    if (inst0_f1_pc_o !== 64'h3004) begin errors++; $display("FAIL simul_head: got %0h expected 3004", inst0_f1_pc_o); end
    idle(1);
  endtask

  task automatic test_slot1_only();
    logic acc;
    step(0, 64'h4000, 1, 64'h4004, 1, 0, 0, acc);
    checks += 2;
    if (inst0_f1_pc_o !== 64'h4004) begin errors++; $display("FAIL slot1_pc0: got %0h expected 4004", inst0_f1_pc_o); end
    if (inst1_f1_valid_o !== 1'b0) begin errors++; $display("FAIL slot1_valid1: got %0b expected 0", inst1_f1_valid_o); end
    idle(1);
  endtask

  task automatic test_flush();
    logic acc;
    step(1, 64'h5000, 1, 64'h5004, 0, 1, 0, acc);
    step(1, 64'h5008, 1, 64'h500C, 0, 1, 0, acc);
    step(1, 64'h5010, 0, '0, 0, 1, 0, acc);
    checks++;
    if (iq_count_o !== 4'd5) begin errors++; $display("FAIL flush_pre: got %0d expected 5", iq_count_o); end
    step(1, 64'h5100, 1, 64'h5104, 0, 1, 1, acc);
    checks += 2;
    if (inst0_f1_valid_o !== 1'b0 || inst1_f1_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b%0b expected 00", inst0_f1_valid_o, inst1_f1_valid_o); end
    if (iq_count_o !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", iq_count_o); end
    idle(1);
  endtask

  task automatic test_wrap();
    logic        acc, s;
    logic [63:0] next_pc;
    int          n_acc;
    obs_q.delete();
    next_pc = 64'h6000;
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      s = ($urandom_range(0, 3) == 0);
      step(1, next_pc, 1, next_pc + 4, s, 0, 0, acc);
      if (acc) begin next_pc += 8; n_acc++; end
    end
    for (int i = 0; i < 8 && mq.size() > 0; i++) idle(1);
    checks++;
    if (obs_q.size() != 2 * n_acc) begin errors++; $display("FAIL wrap_len: got %0d expected %0d", obs_q.size(), 2 * n_acc); end
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== 64'h6000 + 4 * i) begin errors++; $display("FAIL wrap_order: got %0h expected %0h", obs_q[i], 64'h6000 + 4 * i); end
    end
  endtask

  task automatic test_async_reset();
    logic acc;
    step(1, 64'h7000, 1, 64'h7004, 0, 1, 0, acc);
    step(1, 64'h7008, 1, 64'h700C, 0, 1, 0, acc);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (inst0_f1_valid_o !== 1'b0 || inst1_f1_valid_o !== 1'b0 || inst0_f1_pc_o !== '0) begin errors++; $display("FAIL areset_out: got %0b%0b pc %0h expected 00 pc 0", inst0_f1_valid_o, inst1_f1_valid_o, inst0_f1_pc_o); end
    if (iq_count_o !== '0) begin errors++; $display("FAIL areset_count: got %0d expected 0", iq_count_o); end
    if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL areset_ready: got %0b expected 1", fetch_ready_o); end
    mq.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_simultaneous();
    test_slot1_only();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
